// File: rtl/deparser_pkg.sv
// Shared constants for the PHV deparser: PHV field offsets and FSM encodings.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
// Ports: none (package).
package deparser_pkg;

  // PHV metadata layout, bit offsets inside phv_in[255:0]
  localparam int MASK_LO  = 0;   // 32-bit byte write-mask, bit i covers tdata byte i
  localparam int DST_LO   = 32;  // 8-bit one-hot destination port
  localparam int DROP_BIT = 40;  // drop flag

  // Tuser byte that carries the destination port
  localparam int TUSER_DST_LO = 24;

  // Replacement first-beat data sits in the top 256 bits of the PHV
  function automatic int hdr_lo(input int phv_width);
    return phv_width - 256;
  endfunction

  // FSM encodings
  localparam logic [1:0] WAIT_PHV = 2'd0;
  localparam logic [1:0] BODY     = 2'd1;
  localparam logic [1:0] DROP     = 2'd2;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI-Stream output stage.
// Latency: 1 cycle from in_vld to m_axis_tvalid.
// Backpressure: adv = !m_axis_tvalid || m_axis_tready; contents held while stalled.
// Ports: clk/aresetn (sync, active-low); in_vld + in_* beat to load;
//        adv tells the producer a beat can be loaded this cycle; m_axis_* registered output.
module axis_out_reg #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            in_vld,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    in_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  in_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   in_tuser,
  input  logic                            in_tlast,
  output logic                            adv,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  // The register may take a new beat when it is empty or being drained now
  assign adv = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (adv) begin
      // Without a new beat the register empties; payload is left as is
      m_axis_tvalid <= in_vld;
      if (in_vld) begin
        m_axis_tdata <= in_tdata;
        m_axis_tkeep <= in_tkeep;
        m_axis_tuser <= in_tuser;
        m_axis_tlast <= in_tlast;
      end
    end
  end

endmodule

// File: rtl/phv_deparser.sv
// Egress deparser: merges PHV header bytes into the first beat, stamps dst port in tuser, drops flagged packets.
// Latency: 1 cycle from accepted input beat to m_axis_tvalid (registered output stage).
// Backpressure: s_axis_tready follows the output stage (and phv_valid on first beats); drop bodies are always sunk.
// Ports: clk, aresetn (sync, active-low); phv_in/phv_valid/phv_ready header vector handshake;
//        s_axis_* input packet stream; m_axis_* registered output stream; stat_fwd_cnt/stat_drop_cnt packet counters.
// Build option: define DEPARSER_STATS_EN to build the saturating packet counters; otherwise they read 0.
module phv_deparser
  import deparser_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int PHV_WIDTH          = 1124
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [PHV_WIDTH-1:0]            phv_in,
  input  logic                            phv_valid,
  output logic                            phv_ready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     stat_fwd_cnt,
  output logic [31:0]                     stat_drop_cnt
);

  localparam int NB     = C_AXIS_DATA_WIDTH / 8;
  localparam int HDR_LO = hdr_lo(PHV_WIDTH);

  logic [1:0]                     state;
  logic [1:0]                     state_nxt;
  logic                           adv;
  logic                           beat_acc;
  logic                           first_acc;
  logic                           fwd_vld;
  logic                           phv_drop;
  logic [NB-1:0]                  byte_mask;
  logic [7:0]                     dst_port;
  logic [C_AXIS_DATA_WIDTH-1:0]   hdr_dat;
  logic [C_AXIS_DATA_WIDTH-1:0]   merged_dat;
  logic [C_AXIS_DATA_WIDTH-1:0]   out_dat;
  logic [C_AXIS_TUSER_WIDTH-1:0]  out_user;

  assign byte_mask = phv_in[MASK_LO +: NB];
  assign dst_port  = phv_in[DST_LO +: 8];
  assign phv_drop  = phv_in[DROP_BIT];
  assign hdr_dat   = phv_in[HDR_LO +: C_AXIS_DATA_WIDTH];

  // PHV bits between the metadata fields and the header are not used here
  logic unused_phv;
  assign unused_phv = ^phv_in[HDR_LO-1:DROP_BIT+1];

  // Input ready. Gated by reset so nothing is accepted (and phv_ready stays low) while in reset.
  always_comb begin
    s_axis_tready = 1'b0;
    if (aresetn) begin
      case (state)
        WAIT_PHV: s_axis_tready = phv_valid && adv;
        BODY:     s_axis_tready = adv;
        DROP:     s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  assign beat_acc  = s_axis_tvalid && s_axis_tready;
  assign first_acc = beat_acc && (state == WAIT_PHV);
  // The PHV is consumed together with the first beat of its packet
  assign phv_ready = first_acc;
  assign fwd_vld   = beat_acc && ((state == BODY) || ((state == WAIT_PHV) && !phv_drop));

  // Byte-granular header write-back on the first beat
  always_comb begin
    merged_dat = s_axis_tdata;
    for (int i = 0; i < NB; i++) begin
      if (byte_mask[i]) merged_dat[8*i +: 8] = hdr_dat[8*i +: 8];
    end
  end

  always_comb begin
    out_dat  = s_axis_tdata;
    out_user = s_axis_tuser;
    if (state == WAIT_PHV) begin
      out_dat  = merged_dat;
      out_user = {s_axis_tuser[C_AXIS_TUSER_WIDTH-1:TUSER_DST_LO+8], dst_port,
                  s_axis_tuser[TUSER_DST_LO-1:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_PHV: begin
        if (first_acc && !s_axis_tlast) state_nxt = phv_drop ? DROP : BODY;
      end
      BODY, DROP: begin
        if (beat_acc && s_axis_tlast) state_nxt = WAIT_PHV;
      end
      default: state_nxt = WAIT_PHV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) state <= WAIT_PHV;
    else          state <= state_nxt;
  end

  axis_out_reg #(
    .C_AXIS_DATA_WIDTH  (C_AXIS_DATA_WIDTH),
    .C_AXIS_TUSER_WIDTH (C_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_vld        (fwd_vld),
    .in_tdata      (out_dat),
    .in_tkeep      (s_axis_tkeep),
    .in_tuser      (out_user),
    .in_tlast      (s_axis_tlast),
    .adv           (adv),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

`ifdef DEPARSER_STATS_EN
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;

  // Counted per packet on its first beat; both saturate
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else if (first_acc) begin
      if (phv_drop) begin
        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end else begin
        if (fwd_cnt != 32'hFFFF_FFFF) fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end

  assign stat_fwd_cnt  = fwd_cnt;
  assign stat_drop_cnt = drop_cnt;
`else
  assign stat_fwd_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_phv_deparser.sv
// Bench for phv_deparser: directed packet sequences with a beat-level expected queue.
module tb_phv_deparser;

  logic            clk;
  logic            aresetn;
  logic [1123:0]   phv_in;
  logic            phv_valid;
  logic            phv_ready;
  logic [255:0]    s_axis_tdata;
  logic [31:0]     s_axis_tkeep;
  logic [127:0]    s_axis_tuser;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic [255:0]    m_axis_tdata;
  logic [31:0]     m_axis_tkeep;
  logic [127:0]    m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [31:0]     stat_fwd_cnt;
  logic [31:0]     stat_drop_cnt;

  phv_deparser dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .phv_in        (phv_in),
    .phv_valid     (phv_valid),
    .phv_ready     (phv_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .stat_fwd_cnt  (stat_fwd_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_fwd     = 0;
  int    exp_drop    = 0;
  int    exp_pulses  = 0;
  int    phv_pulses  = 0;
  int    exp_bytes   = 0;
  int    out_bytes   = 0;
  bit    rand_tready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Downstream ready: constant high, or a 50% coin flip per cycle
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge
  beat_t mon_cur;
  beat_t mon_held;
  beat_t mon_exp;
  bit    mon_stalled = 0;

  always @(negedge clk) begin
    mon_cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
    if (phv_ready === 1'b1) phv_pulses++;
    if (mon_stalled) check("stall_hold", {m_axis_tvalid, mon_cur}, {1'b1, mon_held});
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("beat_content", mon_cur, mon_exp);
        out_bytes += $countones(m_axis_tkeep);
      end
    end
    mon_stalled = (m_axis_tvalid === 1'b1) && !m_axis_tready && (aresetn === 1'b1);
    mon_held    = mon_cur;
  end

  function automatic logic [1123:0] mk_phv(input logic [31:0] mask, input logic [7:0] dst,
                                           input logic drop, input logic [255:0] hdr);
    logic [1123:0] p;
    p = '0;
    p[104:41]       = {$urandom, $urandom};
    p[1123 -: 256]  = hdr;
    p[31:0]         = mask;
    p[39:32]        = dst;
    p[40]           = drop;
    return p;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] d, input logic [255:0] h,
                                         input logic [31:0] m);
    logic [255:0] r;
    for (int b = 0; b < 32; b++) r[b*8 +: 8] = m[b] ? h[b*8 +: 8] : d[b*8 +: 8];
    return r;
  endfunction

  // Sends the first nsend beats of an nbeats packet; returns the cycles waited for the first beat
  task automatic send_pkt(input int nbeats, input int nsend, input logic [31:0] mask,
                          input logic [7:0] dst, input logic drop, input logic [255:0] hdr,
                          output int first_wait);
    beat_t b;
    int    w;
    first_wait = 0;
    for (int i = 0; i < nsend; i++) begin
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s_axis_tkeep  = (i == nbeats - 1) ? ($urandom | 32'h1) : 32'hFFFF_FFFF;
      s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = (i == nbeats - 1);
      s_axis_tvalid = 1'b1;
      if (i == 0) begin
        phv_in    = mk_phv(mask, dst, drop, hdr);
        phv_valid = 1'b1;
      end
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 500) begin
        w++;
        @(negedge clk);
      end
      if (w >= 500) begin
        check("tready_timeout", w, 0);
        s_axis_tvalid = 1'b0;
        phv_valid     = 1'b0;
        return;
      end
      if (i == 0) begin
        first_wait = w;
        check("phv_ready_first", phv_ready, 1);
        exp_pulses++;
        if (drop) exp_drop++;
        else      exp_fwd++;
      end else begin
        check("phv_ready_body", phv_ready, 0);
      end
      if (!drop) begin
        b.d = (i == 0) ? merge(s_axis_tdata, hdr, mask) : s_axis_tdata;
        b.u = (i == 0) ? {s_axis_tuser[127:32], dst, s_axis_tuser[23:0]} : s_axis_tuser;
        b.k = s_axis_tkeep;
        b.l = s_axis_tlast;
        exp_q.push_back(b);
        exp_bytes += $countones(s_axis_tkeep);
      end
      @(posedge clk);
      #1;
      if (i == 0) phv_valid = 1'b0;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef DEPARSER_STATS_EN
    check(tag, {stat_fwd_cnt, stat_drop_cnt}, {32'(exp_fwd), 32'(exp_drop)});
`else
    check(tag, {stat_fwd_cnt, stat_drop_cnt}, 64'd0);
`endif
  endtask

  initial begin
    logic [255:0] hdr;
    int           fw;
    int           nb;
    logic         dr;

    aresetn       = 1'b0;
    phv_in        = '0;
    phv_valid     = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_ctl", {m_axis_tvalid, m_axis_tlast, phv_ready, s_axis_tready}, 4'b0000);
    check("rst_m_dat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser}, '0);
    check_stats("rst_stats");
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet, header bytes 0-5 replaced with 0xAA, dst 0x04
    hdr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    hdr[47:0] = 48'hAAAA_AAAA_AAAA;
    send_pkt(3, 3, 32'h0000_003F, 8'h04, 1'b0, hdr, fw);
    @(negedge clk);
    check("t1_latency", {m_axis_tvalid, m_axis_tlast}, 2'b11);
    @(posedge clk);
    #1;
    drain();
    check("t1_pulses", phv_pulses, 1);

    // 1-beat packet, mask 0, dst 0x10; next packet accepted the following cycle
    hdr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_pkt(1, 1, 32'h0, 8'h10, 1'b0, hdr, fw);
    send_pkt(2, 2, 32'hFFFF_0000, 8'h01, 1'b0, hdr, fw);
    check("t2_back_to_back", fw, 0);
    drain();

    // 4-beat drop packet followed by a 2-beat forward packet
    exp_fwd  = 0;
    exp_drop = 0;
    aresetn  = 1'b0;
    @(posedge clk);
    #1;
    aresetn  = 1'b1;
    send_pkt(4, 4, 32'hFFFF_FFFF, 8'h02, 1'b1, hdr, fw);
    send_pkt(2, 2, 32'h8000_0001, 8'h08, 1'b0, hdr, fw);
    drain();
    check_stats("t3_stats");

    // Packet data waiting while the PHV is absent for 10 cycles
    s_axis_tdata  = {8{32'hDEAD_BEEF}};
    s_axis_tkeep  = 32'hFFFF_FFFF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4_hold", {s_axis_tready, m_axis_tvalid, phv_ready}, 3'b000);
      @(posedge clk);
      #1;
    end
    send_pkt(1, 1, 32'h0000_0F00, 8'h20, 1'b0, hdr, fw);
    check("t4_first_wait", fw, 0);
    @(negedge clk);
    check("t4_latency", {m_axis_tvalid, m_axis_tlast}, 2'b11);
    @(posedge clk);
    #1;
    drain();

    // 100 mixed packets against a randomly stalling downstream
    rand_tready = 1;
    exp_bytes   = 0;
    out_bytes   = 0;
    for (int p = 0; p < 100; p++) begin
      hdr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nb  = $urandom_range(1, 4);
      dr  = ($urandom_range(0, 3) == 0);
      send_pkt(nb, nb, $urandom, 8'(1 << $urandom_range(0, 7)), dr, hdr, fw);
    end
    drain();
    rand_tready = 0;
    @(posedge clk);
    #1;
    check("t5_bytes", out_bytes, exp_bytes);
    check("t5_pulses", phv_pulses, exp_pulses);
    check_stats("t5_stats");

    // Reset for one cycle in the middle of a packet body
    send_pkt(4, 2, 32'h0000_00FF, 8'h40, 1'b0, hdr, fw);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    aresetn  = 1'b1;
    exp_fwd  = 0;
    exp_drop = 0;
    @(negedge clk);
    check("t6_after_rst", {m_axis_tvalid, phv_ready}, 2'b00);
    check_stats("t6_stats_clr");
    check("t6_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    send_pkt(2, 2, 32'h0000_0003, 8'h80, 1'b0, hdr, fw);
    drain();
    check_stats("t6_stats_after");
    check("t6_pulses", phv_pulses, exp_pulses);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phv_deparser.md
Name: phv_deparser

Overview:
- Egress stage directly downstream of the parse/match stage.
- Consumes one packet header vector (PHV) per packet, together with the matching 256-bit AXI-Stream packet.
- Writes the PHV's header bytes back into the first beat, sets the destination port in tuser, and drops packets the PHV marks for drop.
- Output goes through a single registered AXIS stage toward the output queues.

Parameters:
- C_AXIS_DATA_WIDTH, 256: data width of the input and output streams.
- C_AXIS_TUSER_WIDTH, 128: tuser width.
- PHV_WIDTH, 1124: PHV width; must be at least C_AXIS_DATA_WIDTH+256.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- phv_in  in  PHV_WIDTH  header vector. Bits [PHV_WIDTH-1 -: 256] hold replacement first-beat data. Bits [255:0] are metadata: [31:0] byte write-mask (bit i covers tdata byte i), [39:32] one-hot destination port, [40] drop.
- phv_valid  in  1  PHV available.
- phv_ready  out  1  PHV consumed this cycle.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  input packet stream.
- s_axis_tready  out  1  input ready.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  output stream, registered.
- m_axis_tready  in  1  downstream ready.
- stat_fwd_cnt  out  32  forwarded-packet count (see Optional Feature).
- stat_drop_cnt  out  32  dropped-packet count (see Optional Feature).

Behaviour:
- Reset values: all m_axis_* outputs, phv_ready, the state register and the stat counters are 0. State resets to WAIT_PHV.
- Output stage: adv = !m_axis_tvalid || m_axis_tready. An input beat is accepted only when s_axis_tvalid && s_axis_tready.
- State WAIT_PHV:
  - s_axis_tready = phv_valid && adv.
  - On beat accept, phv_ready=1 for that one cycle.
  - If the drop bit is set: no output is produced. If tlast, stay in WAIT_PHV; else go to DROP.
  - Otherwise load the output register:
    - tdata byte i = mask[i] ? hdr byte i : s_axis_tdata byte i.
    - tuser = s_axis_tuser with [31:24] replaced by dst_port.
    - tkeep and tlast pass through unchanged.
    - Next state is WAIT_PHV if tlast, else BODY.
- State BODY:
  - s_axis_tready = adv.
  - Beats are copied unchanged into the output register.
  - tlast returns the FSM to WAIT_PHV.
- State DROP:
  - s_axis_tready = 1.
  - Beats are discarded; the output register is untouched and still drains.
  - tlast returns the FSM to WAIT_PHV.
- Output register: loads on adv whenever a forwarded beat is accepted. If adv is true and no forwarded beat is accepted, m_axis_tvalid clears.
- Latency: 1 cycle from accepted input beat to m_axis_tvalid.
- Throughput: one beat per cycle while m_axis_tready is high.
- phv_ready is never asserted outside a first-beat accept. A PHV that arrives without packet data is held.
- A single-beat packet gets the header rewrite, the tuser update and tlast on the same beat.
- Reset mid-packet: the partially emitted packet is abandoned and m_axis_tvalid deasserts the next cycle. Upstream is reset together with this block.
- Output is held stable while m_axis_tvalid && !m_axis_tready.

Optional Feature:
- Macro: DEPARSER_STATS_EN.
- Defined: stat_fwd_cnt increments by 1 on each accepted non-drop first beat. stat_drop_cnt increments by 1 on each accepted drop first beat. Both counters saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package deparser_pkg holds:
  - PHV field offsets: MASK_LO=0, DST_LO=32, DROP_BIT=40, HDR_LO=PHV_WIDTH-256.
  - State encodings: WAIT_PHV=0, BODY=1, DROP=2.
- Sub-module axis_out_reg is natural: the one-deep registered AXIS output stage with the adv logic. The FSM and the byte merge stay in the top level.

Test Plan:
- 3-beat packet; PHV mask=32'h0000_003F, hdr bytes 0-5 = 0xAA, dst=8'h04, drop=0 → beat0 bytes 0-5 become 0xAA, other bytes unchanged; tuser[31:24]=0x04; beats 1-2 identical to input; phv_ready pulses exactly once; output appears 1 cycle after input.
- 1-beat packet with tlast on first beat, mask=0, dst=8'h10 → data unchanged, tuser[31:24]=0x10, FSM back in WAIT_PHV; next packet accepted the following cycle.
- 4-beat packet with drop=1 followed by a 2-beat forward packet → no output beats for the first packet; second packet is emitted intact; stat_drop_cnt=1 and stat_fwd_cnt=1 with DEPARSER_STATS_EN.
- Packet data present, phv_valid held low for 10 cycles → s_axis_tready=0, no output; packet flows 1 cycle after phv_valid rises.
- Random m_axis_tready at 50% over 100 mixed packets → no beat lost, duplicated or reordered; outputs stable while stalled; byte count matches input minus dropped packets.
- aresetn low for 1 cycle mid-BODY → next cycle m_axis_tvalid=0, phv_ready=0, counters=0; next packet is processed from WAIT_PHV.
